risc_spm: RTL and testbench
===========================

Name: risc_spm

Overview:
- 8-bit stored-program RISC machine: multi-cycle control FSM, 4×8 register file (R0–R3), ALU with zero flag, PC, IR and MAR.
- Unified 256×8 program/data memory lives inside the block.
- Top-level CPU with no external data ports; programs are loaded by backdoor writes to the memory array while in reset.

Parameters:
- None. Word width is fixed at 8 bits and memory depth at 256 words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.

Behaviour:
- Memory:
  - Sub-instance named Ram containing reg array memory[0:255] of 8 bits; the bench writes Ram.memory[i] hierarchically.
  - Read is combinational (data = memory[MAR]); write is synchronous.
  - Memory is not cleared by reset.
- Reset (rst=0):
  - PC, IR, MAR, R0–R3 and Z all go to 0.
  - FSM goes to FET1.
- Instruction format:
  - Bits [7:4] are the opcode, [3:2] are field A, [1:0] are field B.
  - Two-byte instructions (RD, WR, BR, BRZ) carry an operand byte at PC+1.
- Opcodes:
  - NOP 0000.
  - ADD 0001: R[A] <= R[A] + R[B].
  - SUB 0010: R[A] <= R[A] - R[B].
  - AND 0011: R[A] <= R[A] & R[B].
  - NOT 0100: R[A] <= ~R[B].
  - RD 0101: R[A] <= mem[op].
  - WR 0110: mem[op] <= R[A].
  - BR 0111: PC <= mem[op] (indirect).
  - BRZ 1000: if Z, PC <= mem[op]; else PC <= PC+1 (skip operand).
  - HALT 1111.
  - 1001–1110 are illegal and go to HALT.
- Arithmetic:
  - 8-bit modulo; carry and borrow are discarded.
  - Z <= (result == 0) on ALU ops only. RD, WR, branches and NOP leave Z unchanged.
- FSM states and actions:
  - FET1: MAR <= PC.
  - FET2: IR <= mem[MAR]; PC <= PC+1.
  - DEC: dispatch on opcode. NOP, and BRZ with Z=0, return to FET1 (BRZ also does PC <= PC+1).
  - EX1 (ALU ops): write R[A], update Z, then FET1.
  - RD1/WR1/BR1: MAR <= PC.
  - RD2/WR2/BR2: MAR <= mem[MAR]; PC <= PC+1 (the PC increment is irrelevant for BR).
  - RD3: R[A] <= mem[MAR].
  - WR3: mem[MAR] <= R[A].
  - BR3: PC <= mem[MAR].
  - After any *3 state, return to FET1.
  - HALT: absorbing; only reset leaves it.
- Cycle counts:
  - NOP and not-taken BRZ: 3.
  - ALU ops: 4.
  - RD, WR, BR and taken BRZ: 6.
- Wrap-around:
  - PC increments modulo 256.
  - A two-byte instruction at 255 takes its operand from address 0.
- Reset asserted mid-instruction aborts it immediately with no partial register write. A memory write occurs only on the WR3 edge.

Decomposition:
- Shared package risc_spm_pkg holds:
  - opcode localparams (NOP…HALT),
  - FSM state enum,
  - register-index type.
- One natural sub-module: risc_spm_mem, a 256×8 memory with combinational read and synchronous write, instantiated as Ram with array memory.
- Datapath and controller stay in the top level.

Test Plan:
- Reset with all memory zeroed, release rst: PC increments by 1 every 3 cycles (NOP stream), wraps 255→0, and all registers stay 0.
- Loop program:
  - Program: mem[0]=00; RD R2,130; RD R3,131; RD R1,128; RD R0,129; [9] SUB 0x24; [10] BRZ 0x80,134; [12] ADD 0x1E; [13] BR 0x73,140.
  - Data: mem[128]=6, [129]=1, [130]=2, [131]=0, [134]=139, [135]=0, [139]=F0, [140]=9.
  - Required result: halts with R0=1, R1=0, R2=2, R3=10 and Z=1, entering HALT 125 cycles after rst release.
- WR/RD round-trip: RD R1 from a cell holding 0xA5, WR R1 to 200, RD R2 from 200 → mem[200]=0xA5 and R2=0xA5.
- ALU and flags:
  - AND of 0xF0 and 0x0F → result 0, Z=1.
  - NOT of 0x00 → 0xFF, Z=0.
  - SUB of 0x00-0x01 → 0xFF.
  - A following RD leaves Z unchanged.
- BRZ with Z=0 falls through to PC+2; an illegal opcode 0x90 enters HALT, and PC stays frozen for 20 cycles.
- Asserting rst during RD2 → all registers and PC read 0 asynchronously; after release, execution restarts from address 0.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// risc_spm_pkg : shared opcodes, FSM state encoding and ALU helper for the risc_spm CPU.
// Revision 1.0
`default_nettype none

package risc_spm_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_RD   = 4'b0101;
  localparam logic [3:0] OP_WR   = 4'b0110;
  localparam logic [3:0] OP_BR   = 4'b0111;
  localparam logic [3:0] OP_BRZ  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [3:0] {
    S_FET1 = 4'd0,
    S_FET2 = 4'd1,
    S_DEC  = 4'd2,
    S_EX1  = 4'd3,
    S_RD1  = 4'd4,
    S_RD2  = 4'd5,
    S_RD3  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_WR3  = 4'd9,
    S_BR1  = 4'd10,
    S_BR2  = 4'd11,
    S_BR3  = 4'd12,
    S_HALT = 4'd13
  } state_t;

  // Modulo-256 result; carry and borrow are simply dropped.
  function automatic logic [7:0] alu_eval(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    logic [7:0] res;
    res = 8'h00;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_NOT:  res = ~b;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc_spm_mem.sv
// risc_spm_mem : 256x8 unified program/data memory, combinational read, synchronous write.
// Revision 1.0
`default_nettype none

module risc_spm_mem (
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  // Contents survive reset; programs are preloaded through the array itself.
  logic [7:0] memory [0:255];

  always @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = memory[addr_i];

endmodule

`default_nettype wire

// File: rtl/risc_spm.sv
// risc_spm : 8-bit multi-cycle stored-program CPU (controller + datapath) with internal memory.
// Revision 1.0
`default_nettype none

module risc_spm
  import risc_spm_pkg::*;
(
  input logic clk,
  input logic rst
);

  state_t          state_q;
  logic [7:0]      pc_q;
  logic [7:0]      ir_q;
  logic [7:0]      mar_q;
  logic [3:0][7:0] r_q;
  logic            z_q;

  logic [3:0]      w_opc;
  reg_idx_t        w_ra;
  reg_idx_t        w_rb;
  logic [7:0]      w_alu_res;
  logic [7:0]      w_mem_rdata;
  logic            w_mem_we;

  assign w_opc     = ir_q[7:4];
  assign w_ra      = ir_q[3:2];
  assign w_rb      = ir_q[1:0];
  assign w_alu_res = alu_eval(w_opc, r_q[w_ra], r_q[w_rb]);

  // Memory is only ever written on the edge that leaves WR3.
  assign w_mem_we  = (state_q == S_WR3);

  risc_spm_mem Ram (
    .clk_i   (clk),
    .we_i    (w_mem_we),
    .addr_i  (mar_q),
    .wdata_i (r_q[w_ra]),
    .rdata_o (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FET1;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      mar_q   <= 8'h00;
      r_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FET1: begin
          mar_q   <= pc_q;
          state_q <= S_FET2;
        end
        S_FET2: begin
          ir_q    <= w_mem_rdata;
          pc_q    <= pc_q + 8'd1;
          state_q <= S_DEC;
        end
        S_DEC: begin
          case (w_opc)
            OP_NOP:                         state_q <= S_FET1;
            OP_ADD, OP_SUB, OP_AND, OP_NOT: state_q <= S_EX1;
            OP_RD:                          state_q <= S_RD1;
            OP_WR:                          state_q <= S_WR1;
            OP_BR:                          state_q <= S_BR1;
            OP_BRZ: begin
              // Not taken: step over the operand byte.
              if (z_q) begin
                state_q <= S_BR1;
              end else begin
                pc_q    <= pc_q + 8'd1;
                state_q <= S_FET1;
              end
            end
            default:                        state_q <= S_HALT;
          endcase
        end
        S_EX1: begin
          r_q[w_ra] <= w_alu_res;
          z_q       <= (w_alu_res == 8'h00);
          state_q   <= S_FET1;
        end
        S_RD1: begin
          mar_q   <= pc_q;
          state_q <= S_RD2;
        end
        S_RD2: begin
          mar_q   <= w_mem_rdata;
          pc_q    <= pc_q + 8'd1;
          state_q <= S_RD3;
        end
        S_RD3: begin
          r_q[w_ra] <= w_mem_rdata;
          state_q   <= S_FET1;
        end
        S_WR1: begin
          mar_q   <= pc_q;
          state_q <= S_WR2;
        end
        S_WR2: begin
          mar_q   <= w_mem_rdata;
          pc_q    <= pc_q + 8'd1;
          state_q <= S_WR3;
        end
        S_WR3: begin
          state_q <= S_FET1;
        end
        S_BR1: begin
          mar_q   <= pc_q;
          state_q <= S_BR2;
        end
        S_BR2: begin
          mar_q   <= w_mem_rdata;
          state_q <= S_BR3;
        end
        S_BR3: begin
          pc_q    <= w_mem_rdata;
          state_q <= S_FET1;
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_risc_spm.sv
// tb_risc_spm : program-level scoreboard bench for risc_spm against an instruction-set model.
// Revision 1.0
`default_nettype none

module tb_risc_spm;
  import risc_spm_pkg::*;

  logic clk;
  logic rst;

  risc_spm dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [3:0][7:0] r;
    logic            z;
    logic [7:0]      pc;
    int              cyc;
    logic [7:0]      maddr;
    logic [7:0]      mval;
  } want_t;

  want_t      sb[$];
  logic [7:0] img [256];
  int         n_checks;
  int         n_errors;
  int         cyc_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc_cnt <= 0;
    else      cyc_cnt <= cyc_cnt + 1;
  end

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Monitor: the first HALT cycle after a release is the DUT's "response".
  initial begin
    want_t w;
    forever begin
      @(negedge clk);
      if (rst && dut.state_q == S_HALT && sb.size() > 0) begin
        w = sb.pop_front();
        check({w.name, "_cycles"}, cyc_cnt, w.cyc);
        check({w.name, "_pc"}, int'(dut.pc_q), int'(w.pc));
        for (int i = 0; i < 4; i++)
          check($sformatf("%s_r%0d", w.name, i), int'(dut.r_q[i]), int'(w.r[i]));
        check({w.name, "_z"}, int'(dut.z_q), int'(w.z));
        check({w.name, "_mem"}, int'(dut.Ram.memory[w.maddr]), int'(w.mval));
      end
    end
  end

  // Instruction-level reference: each instruction applied whole, cycles by class.
  task automatic model_run(input string name, input logic [7:0] maddr, output want_t w);
    logic [7:0] m [256];
    logic [7:0] r [4];
    logic       z;
    logic [7:0] pc, ir, op, res;
    int         cyc, a, b;
    bit         done;
    m = img;
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    z = 1'b0; pc = 8'h00; cyc = 0; done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      ir = m[pc]; pc = pc + 8'd1;
      a = int'(ir[3:2]); b = int'(ir[1:0]);
      case (ir[7:4])
        4'd0: cyc += 3;
        4'd1, 4'd2, 4'd3, 4'd4: begin
          if (ir[7:4] == 4'd1)      res = r[a] + r[b];
          else if (ir[7:4] == 4'd2) res = r[a] - r[b];
          else if (ir[7:4] == 4'd3) res = r[a] & r[b];
          else                      res = ~r[b];
          r[a] = res; z = (res == 8'h00); cyc += 4;
        end
        4'd5: begin op = m[pc]; pc = pc + 8'd1; r[a] = m[op]; cyc += 6; end
        4'd6: begin op = m[pc]; pc = pc + 8'd1; m[op] = r[a]; cyc += 6; end
        4'd7: begin op = m[pc]; pc = m[op]; cyc += 6; end
        4'd8: begin
          if (z) begin op = m[pc]; pc = m[op]; cyc += 6; end
          else   begin pc = pc + 8'd1; cyc += 3; end
        end
        default: begin cyc += 3; done = 1'b1; end
      endcase
    end
    w.name = name;
    for (int i = 0; i < 4; i++) w.r[i] = r[i];
    w.z = z; w.pc = pc; w.cyc = cyc; w.maddr = maddr; w.mval = m[maddr];
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic load_img();
    for (int i = 0; i < 256; i++) dut.Ram.memory[i] = img[i];
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
    check({name, "_reached_halt_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_prog(input want_t w);
    rst = 1'b0;
    @(negedge clk);
    load_img();
    sb.push_back(w);
    @(negedge clk);
    rst = 1'b1;
    wait_done(w.name);
  endtask

  function automatic want_t mk(input string name, input logic [7:0] r0, input logic [7:0] r1,
                               input logic [7:0] r2, input logic [7:0] r3, input logic z,
                               input logic [7:0] pc, input int cyc,
                               input logic [7:0] maddr, input logic [7:0] mval);
    want_t w;
    w.name = name; w.r[0] = r0; w.r[1] = r1; w.r[2] = r2; w.r[3] = r3;
    w.z = z; w.pc = pc; w.cyc = cyc; w.maddr = maddr; w.mval = mval;
    return w;
  endfunction

  task automatic gen_random();
    int         pc, ptr, k;
    logic [3:0] hop;
    clear_img();
    for (int i = 128; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
    pc = 0; ptr = 230;
    while (pc < 100) begin
      k = $urandom_range(0, 8);
      if (k == 0) begin
        img[pc] = 8'h00; pc += 1;
      end else if (k <= 4) begin
        img[pc] = {4'(k), 4'($urandom_range(0, 15))}; pc += 1;
      end else if (k <= 6) begin
        img[pc]   = {4'(k), 4'($urandom_range(0, 15))};
        img[pc+1] = 8'($urandom_range(128, 229));
        pc += 2;
      end else if (ptr <= 254) begin
        // Branch targets converge on the next instruction so the program stays finite.
        img[pc]   = {4'(k), 4'($urandom_range(0, 15))};
        img[pc+1] = 8'(ptr);
        img[ptr]  = 8'(pc + 2);
        ptr++; pc += 2;
      end else begin
        img[pc] = 8'h00; pc += 1;
      end
    end
    hop = 4'($urandom_range(9, 15));
    img[pc] = {hop, 4'($urandom_range(0, 15))};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    want_t w;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    clear_img();
    load_img();
    repeat (2) @(negedge clk);

    check("reset_pc", int'(dut.pc_q), 0);
    check("reset_ir", int'(dut.ir_q), 0);
    check("reset_mar", int'(dut.mar_q), 0);
    check("reset_regs", int'(dut.r_q), 0);
    check("reset_z", int'(dut.z_q), 0);
    check("reset_state", int'(dut.state_q), int'(S_FET1));

    // NOP stream: one PC step every three cycles, wrapping at 256.
    rst = 1'b1;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (c % 3 == 0) check($sformatf("nop_pc_c%0d", c), int'(dut.pc_q), (c / 3) % 256);
    end
    check("nop_regs", int'(dut.r_q), 0);
    check("nop_z", int'(dut.z_q), 0);

    // Countdown loop program.
    clear_img();
    img[0] = 8'h00; img[1] = 8'h58; img[2] = 8'd130; img[3] = 8'h5C; img[4] = 8'd131;
    img[5] = 8'h54; img[6] = 8'd128; img[7] = 8'h50; img[8] = 8'd129; img[9] = 8'h24;
    img[10] = 8'h80; img[11] = 8'd134; img[12] = 8'h1E; img[13] = 8'h73; img[14] = 8'd140;
    img[128] = 8'd6; img[129] = 8'd1; img[130] = 8'd2; img[131] = 8'd0;
    img[134] = 8'd139; img[135] = 8'd0; img[139] = 8'hF0; img[140] = 8'd9;
    run_prog(mk("loop", 8'd1, 8'd0, 8'd2, 8'd10, 1'b1, 8'd140, 125, 8'd128, 8'd6));

    // AND to zero, then RD/WR round trip must leave Z set.
    clear_img();
    img[0] = 8'h50; img[1] = 8'd100; img[2] = 8'h54; img[3] = 8'd101; img[4] = 8'h31;
    img[5] = 8'h58; img[6] = 8'd102; img[7] = 8'h68; img[8] = 8'd200;
    img[9] = 8'h5C; img[10] = 8'd200; img[11] = 8'hF0;
    img[100] = 8'hF0; img[101] = 8'h0F; img[102] = 8'hA5;
    run_prog(mk("andwr", 8'h00, 8'h0F, 8'hA5, 8'hA5, 1'b1, 8'd12, 37, 8'd200, 8'hA5));

    // NOT 0, SUB underflow, BRZ fall-through, illegal opcode.
    clear_img();
    img[0] = 8'h50; img[1] = 8'd100; img[2] = 8'h54; img[3] = 8'd101; img[4] = 8'h48;
    img[5] = 8'h21; img[6] = 8'h80; img[7] = 8'd50; img[8] = 8'h90;
    img[100] = 8'h00; img[101] = 8'h01; img[50] = 8'd60; img[60] = 8'hF0;
    run_prog(mk("notsub", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 8'd9, 26, 8'd101, 8'h01));
    repeat (20) @(negedge clk);
    check("halt_pc_frozen", int'(dut.pc_q), 9);
    check("halt_state_held", int'(dut.state_q), int'(S_HALT));

    // Two-byte instruction at 255 fetches its operand from address 0.
    clear_img();
    img[0] = 8'h70; img[1] = 8'd250; img[250] = 8'd255; img[255] = 8'h54; img[112] = 8'h3C;
    run_prog(mk("wrap", 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0, 8'd2, 15, 8'd250, 8'd255));

    // Reset during RD2 of the second instruction.
    clear_img();
    img[0] = 8'h54; img[1] = 8'd16; img[2] = 8'h58; img[3] = 8'd17; img[4] = 8'hF0;
    img[16] = 8'h77; img[17] = 8'h33;
    rst = 1'b0;
    @(negedge clk);
    load_img();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_in_rd2", int'(dut.state_q), int'(S_RD2));
    check("midrst_r1_before", int'(dut.r_q[1]), 8'h77);
    rst = 1'b0;
    #1;
    check("midrst_regs", int'(dut.r_q), 0);
    check("midrst_pc", int'(dut.pc_q), 0);
    check("midrst_mar", int'(dut.mar_q), 0);
    check("midrst_state", int'(dut.state_q), int'(S_FET1));
    @(negedge clk);
    sb.push_back(mk("midrst_rerun", 8'h00, 8'h77, 8'h33, 8'h00, 1'b0, 8'd5, 15, 8'd17, 8'h33));
    rst = 1'b1;
    wait_done("midrst_rerun");

    // Random straight-line programs against the instruction-level model.
    for (int t = 0; t < 10; t++) begin
      gen_random();
      model_run($sformatf("rand%0d", t), 8'($urandom_range(128, 229)), w);
      run_prog(w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
